// File: rtl/dco_therm_decode_if.sv
// Bus bundle for the DCO thermometer decoder.
// Handshake: therm_valid qualifies therm_in for exactly one cycle. There is
// no ready, so every therm_valid is accepted. code_valid is a one-cycle pulse
// that qualifies code_out and bubble_err. err_cnt and code_stable are levels.
interface dco_therm_decode_if;
  logic [127:0] therm_in;
  logic         therm_valid;
  logic         err_clr;
  logic [7:0]   code_out;
  logic         code_valid;
  logic         bubble_err;
  logic [7:0]   err_cnt;
  logic         code_stable;

  // Drives the thermometer bus and observes the decoder results.
  modport master (
    output therm_in, therm_valid, err_clr,
    input  code_out, code_valid, bubble_err, err_cnt, code_stable
  );

  // Decoder side.
  modport slave (
    input  therm_in, therm_valid, err_clr,
    output code_out, code_valid, bubble_err, err_cnt, code_stable
  );
endinterface

// File: rtl/dco_therm_decode.sv
// Registered thermometer-to-binary decoder for the DCO coarse-control bus.
// Stage 1 captures the word and a well-formed flag. Stage 2 popcounts it.
// A monitor counts bubbled words and reports when the code has held steady.
module dco_therm_decode #(
  parameter int unsigned STABLE_LEN = 16
) (
  input logic              clk,
  input logic              reset,
  dco_therm_decode_if.slave bus
);

  localparam logic [7:0] LP_LEN = 8'(STABLE_LEN);

  logic [127:0] r_s1_word;
  logic         r_s1_wf;
  logic         r_s1_valid;
  logic [7:0]   r_code;
  logic         r_bub;
  logic         r_code_valid;
  logic [7:0]   r_err_cnt;
  logic [7:0]   r_stab_cnt;
  logic [7:0]   r_last_code;
  logic         r_stable;

  logic [127:0] w_plus1;
  logic         w_wf;
  logic [7:0]   w_pop;
  logic [7:0]   w_next_cnt;
  logic [7:0]   w_next_last;

  // A well-formed word plus one is a single power of two with no overlap.
  // The carry out of bit 127 is dropped, so all-ones counts as well-formed.
  assign w_plus1 = bus.therm_in + 128'd1;
  assign w_wf    = ((bus.therm_in & w_plus1) == 128'd0);

  // Stage 1: capture the sample and its well-formed flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_word  <= '0;
      r_s1_wf    <= 1'b0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= bus.therm_valid;
      if (bus.therm_valid) begin
        r_s1_word <= bus.therm_in;
        r_s1_wf   <= w_wf;
      end
    end
  end

  // Population count of the stage-1 word. Bubbled words use it too.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 128; i++) begin
      w_pop = w_pop + 8'(r_s1_word[i]);
    end
  end

  // Stage 2: register the decoded code. Results hold between samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_code       <= '0;
      r_bub        <= 1'b0;
      r_code_valid <= 1'b0;
    end else begin
      r_code_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_code <= w_pop;
        r_bub  <= ~r_s1_wf;
      end
    end
  end

  // Saturating bubble counter. A clear wins over a coincident error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= '0;
    end else if (bus.err_clr) begin
      r_err_cnt <= '0;
    end else if (r_code_valid && r_bub && (r_err_cnt != 8'd255)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // Next stable-run length and reference code. Cycles without a sample
  // leave both unchanged, so gaps do not break a run.
  always_comb begin
    w_next_cnt  = r_stab_cnt;
    w_next_last = r_last_code;
    if (r_code_valid) begin
      if (r_bub) begin
        w_next_cnt = '0;
      end else if ((r_code == r_last_code) && (r_stab_cnt != 8'd0)) begin
        w_next_cnt = (r_stab_cnt == LP_LEN) ? r_stab_cnt : r_stab_cnt + 8'd1;
      end else begin
        w_next_cnt  = 8'd1;
        w_next_last = r_code;
      end
    end
  end

  // Stability tracker state and its registered flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stab_cnt  <= '0;
      r_last_code <= '0;
      r_stable    <= 1'b0;
    end else begin
      r_stab_cnt  <= w_next_cnt;
      r_last_code <= w_next_last;
      r_stable    <= (w_next_cnt == LP_LEN);
    end
  end

  assign bus.code_out    = r_code;
  assign bus.code_valid  = r_code_valid;
  assign bus.bubble_err  = r_bub;
  assign bus.err_cnt     = r_err_cnt;
  assign bus.code_stable = r_stable;

endmodule

// File: doc/dco_therm_decode.md
# dco_therm_decode

Registered thermometer-to-binary decoder and code monitor for the DCO coarse-control bus. It sits on the 128-bit thermometer bus between the DCO code encoder and the DCO model. It recovers the applied 8-bit DCO code, flags malformed (bubbled) thermometer words, counts errors, and reports when the applied code has held steady, for loop-lock monitoring.

## Interface
Parameters:
- STABLE_LEN, 16 — consecutive identical valid codes required before code_stable asserts; legal range 2..255.

Ports:
- clk  input  1  — single system clock; all logic on rising edge.
- reset  input  1  — asynchronous, active-low reset (asserts immediately, releases synchronously to clk).
- therm_in  input  128  — thermometer word; bit i set means element i enabled; a well-formed word for code k has bits 0..k-1 set, all others clear.
- therm_valid  input  1  — therm_in is sampled this cycle.
- err_clr  input  1  — single-cycle pulse that clears err_cnt.
- code_out  output  8  — decoded code, 0..128.
- code_valid  output  1  — code_out and bubble_err are valid this cycle (one-cycle pulse per sample).
- bubble_err  output  1  — the sample was not a well-formed thermometer word; qualified by code_valid.
- err_cnt  output  8  — count of bubble errors, saturating at 255.
- code_stable  output  1  — level; the last STABLE_LEN valid, error-free samples carried identical codes.

## Operation
- Stage 1, on therm_valid:
  - Register therm_in.
  - Register well-formed flag = ((therm_in & (therm_in + 1)) == 0), computed at 128-bit width with the carry out of bit 127 dropped.
- Stage 2:
  - code_out = population count of the stage-1 word, 8-bit result, range 0..128.
  - bubble_err = inverse of the stage-1 well-formed flag.
  - code_valid = stage-1 valid, delayed by one cycle.
- Popcount is used even for bubbled words. Example: bits {0,1,3} gives code_out 3 with bubble_err 1.
- All-ones input decodes to 128. The encoder produces all-ones for every code ≥ 128, so codes above 128 are not recoverable by design.
- Error counter:
  - When code_valid and bubble_err are both 1, err_cnt increments, holding at 255 once saturated.
  - err_clr has priority: if err_clr coincides with an error, err_cnt becomes 0 and that error is not counted.
- Stability tracker, evaluated on each code_valid:
  - bubble_err=1: stable count cleared to 0.
  - bubble_err=0, code_out equals the last code, and count > 0: count = min(count+1, STABLE_LEN).
  - Any other case: count = 1 and last code = code_out.
  - code_stable = (count == STABLE_LEN).
  - Cycles without code_valid leave the tracker unchanged; gaps do not break stability.

## Timing
- Latency: therm_valid at cycle N gives code_valid, code_out and bubble_err at cycle N+2.
- Throughput: one sample per cycle. No backpressure: every therm_valid produces exactly one code_valid.
- err_cnt updates at N+3 for a bubbled sample presented at N.
- code_stable updates at N+3 and can rise no earlier than the cycle after the STABLE_LEN-th matching code_valid.
- code_out and bubble_err hold their last values while code_valid=0.
- Reset values: code_out=0, code_valid=0, bubble_err=0, err_cnt=0, code_stable=0. Internal valids, stable count and last code are also 0.
- Reset mid-operation flushes both pipeline stages: no code_valid is emitted for samples in flight. The first sample after release is treated as a fresh start (count becomes 1).

## Test plan
- Clean codes: drive therm_in for codes 0, 1, 37, 127 on back-to-back cycles -> code_valid on four consecutive cycles starting N+2, code_out 0, 1, 37, 127, bubble_err 0, err_cnt stays 0.
- Boundary: all-ones therm_in -> code_out 128, bubble_err 0. Word with only bit 127 set -> code_out 1, bubble_err 1, err_cnt 1.
- Stability (STABLE_LEN=4):
  - Code 50 ×3 -> code_stable 0; 4th sample -> code_stable 1.
  - Then code 51 -> code_stable drops.
  - A bubbled sample amid repeated 50s restarts the count, so 4 more clean 50s are needed.
- Error saturation/clear: 300 bubbled samples -> err_cnt 255. err_clr coincident with a further error -> err_cnt 0. Next error -> 1.
- Gaps: code 20 on alternate cycles with therm_valid low between, STABLE_LEN=4 -> code_stable asserts after the 4th sample; outputs hold between samples.
- Reset mid-flight: assert reset one cycle after therm_valid -> no code_valid appears. All outputs 0 immediately. After release, code 9 -> code_out 9 at N+2, count restarts.
